irq_ctrl: RTL and testbench

//   Interrupt aggregator downstream of the interval timers and other peripherals' irq outputs.

---
 rtl/irq_ctrl_pkg.sv | 11 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctrl.sv | 120 ++++++++++++
 tb/tb_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt aggregator: register map and bus/line limits.
package irq_ctrl_pkg;
  localparam int DATA_W  = 16;
  localparam int MAX_IRQ = 16;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_RAW      = 3'd4;
endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority; idx is 0 when nothing is set.
module irq_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: per-line level/edge capture, masking, priority encode, 16-bit slave regs.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop input synchronizer for asynchronous sources.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq_out,
  output logic [IDX_W-1:0]  irq_idx
);

  logic [N_IRQ-1:0]  cap_in;
  logic [N_IRQ-1:0]  prev_q;
  logic [N_IRQ-1:0]  pending;
  logic [N_IRQ-1:0]  mask;
  logic [N_IRQ-1:0]  edge_sel;
  logic [N_IRQ-1:0]  active;
  logic [N_IRQ-1:0]  rise;
  logic [N_IRQ-1:0]  w1c;
  logic              wr;
  logic              act_vld;
  logic [IDX_W-1:0]  act_idx;
  logic [DATA_W-1:0] rd_data;
  logic              unused_wd;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync_p0;
  logic [N_IRQ-1:0] sync_p1;

  // Synchronizer stages
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= irq_in;
      sync_p1 <= sync_p0;
    end
  end

  assign cap_in = sync_p1;
`else
  assign cap_in = irq_in;
`endif

  assign wr        = chipselect & ~write_n;
  assign rise      = cap_in & ~prev_q;
  assign w1c       = (wr && address == ADDR_PENDING) ? writedata[N_IRQ-1:0] : '0;
  assign active    = pending & mask;
  assign unused_wd = ^writedata;

  // prev_q follows the input even in reset so release cannot look like an edge.
  always_ff @(posedge clk) begin
    prev_q <= cap_in;
  end

  // Capture stage: level lines track the input, edge lines set on rise (set beats W1C).
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      edge_sel <= '0;
    end else begin
      pending <= (~edge_sel & cap_in) | (edge_sel & (rise | (pending & ~w1c)));
      if (wr && address == ADDR_MASK)     mask     <= writedata[N_IRQ-1:0];
      if (wr && address == ADDR_EDGE_SEL) edge_sel <= writedata[N_IRQ-1:0];
    end
  end

  irq_prio_enc #(
    .N     (N_IRQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (active),
    .valid (act_vld),
    .idx   (act_idx)
  );

  // Output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_out <= 1'b0;
      irq_idx <= '0;
    end else begin
      irq_out <= act_vld;
      irq_idx <= act_idx;
    end
  end

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_PENDING:  rd_data[N_IRQ-1:0] = pending;
      ADDR_MASK:     rd_data[N_IRQ-1:0] = mask;
      ADDR_EDGE_SEL: rd_data[N_IRQ-1:0] = edge_sel;
      ADDR_ACTIVE: begin
        rd_data[DATA_W-1]  = irq_out;
        rd_data[IDX_W-1:0] = irq_idx;
      end
      ADDR_RAW:      rd_data[N_IRQ-1:0] = cap_in;
      default:       rd_data = '0;
    endcase
  end

  // Read data stage; reads need no chipselect.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_data;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a cycle-level behavioural model and literal spot checks.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SD  = 2;
`else
  localparam int SD  = 0;
`endif
  localparam int LAT = SD + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = 8'h01;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        irq_out;
  logic [3:0]  irq_idx;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  irq_ctrl #(.N_IRQ(8), .IDX_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_out    (irq_out),
    .irq_idx    (irq_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_pend, m_mask, m_esel, m_prev, m_s1, m_s2;
  logic        m_out;
  logic [3:0]  m_idx;
  logic [15:0] m_rd;

  always @(posedge clk) begin
    logic [7:0]  cap, act, np;
    logic [15:0] rv;
    logic [3:0]  lo;
    logic        found, wrs;
    cap = (SD == 0) ? irq_in : m_s2;
    act = m_pend & m_mask;
    found = 1'b0;
    lo = 4'd0;
    for (int i = 0; i < 8; i++)
      if (!found && act[i]) begin lo = 4'(i); found = 1'b1; end
    case (address)
      3'd0: rv = {8'h00, m_pend};
      3'd1: rv = {8'h00, m_mask};
      3'd2: rv = {8'h00, m_esel};
      3'd3: rv = {m_out, 11'b0, m_idx};
      3'd4: rv = {8'h00, cap};
      default: rv = 16'h0000;
    endcase
    wrs = chipselect && !write_n;
    np = m_pend;
    for (int i = 0; i < 8; i++) begin
      if (!m_esel[i]) np[i] = cap[i];
      else if (cap[i] && !m_prev[i]) np[i] = 1'b1;
      else if (wrs && address == 3'd0 && writedata[i]) np[i] = 1'b0;
    end
    m_prev = cap;
    if (reset) begin
      m_pend = 8'h00; m_mask = 8'h00; m_esel = 8'h00;
      m_out = 1'b0; m_idx = 4'd0; m_rd = 16'h0000;
      m_s1 = 8'h00; m_s2 = 8'h00;
    end else begin
      m_pend = np;
      if (wrs && address == 3'd1) m_mask = writedata[7:0];
      if (wrs && address == 3'd2) m_esel = writedata[7:0];
      m_out = found;
      m_idx = lo;
      m_rd  = rv;
      m_s2  = m_s1;
      m_s1  = irq_in;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq_out", {15'b0, irq_out}, {15'b0, m_out});
      check("model_irq_idx", {12'b0, irq_idx}, {12'b0, m_idx});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0000;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    @(negedge clk);
    irq_in = 8'h00;
  endtask

  initial begin
    int k;
    // 1: reset with line 0 held high, level mode
    idle(3);
    check("t1_out_in_reset", {15'b0, irq_out}, 16'h0000);
    reset = 1'b0;
    idle(SD);
    wr(3'd1, 16'h0001);
    check("t1_out_after_mask", {15'b0, irq_out}, 16'h0000);
    idle(1);
    check("t1_out", {15'b0, irq_out}, 16'h0001);
    check("t1_idx", {12'b0, irq_idx}, 16'h0000);
    irq_in = 8'h00;

    // 2: edge capture on line 2, then W1C
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    idle(SD + 2);
    pulse(8'h04);
    idle(SD);
    rd(3'd0, 16'h0004, "t2_pending");
    check("t2_out", {15'b0, irq_out}, 16'h0001);
    check("t2_idx", {12'b0, irq_idx}, 16'h0002);
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0000, "t2_pending_clr");
    check("t2_out_clr", {15'b0, irq_out}, 16'h0000);

    // 3: rising edge coincides with W1C; the set wins
    pulse(8'h04);
    idle(SD + 1);
    irq_in = 8'h04;
    idle(SD);
    wr(3'd0, 16'h0004);
    irq_in = 8'h00;
    rd(3'd0, 16'h0004, "t3_pending");
    check("t3_out", {15'b0, irq_out}, 16'h0001);
    wr(3'd0, 16'h0004);
    idle(SD + 2);
    check("t3_out_clr", {15'b0, irq_out}, 16'h0000);

    // 4: two simultaneous edges, priority order
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h00FF);
    pulse(8'h28);
    idle(SD + 1);
    check("t4_idx3", {12'b0, irq_idx}, 16'h0003);
    wr(3'd0, 16'h0008);
    idle(1);
    check("t4_idx5", {12'b0, irq_idx}, 16'h0005);
    check("t4_out5", {15'b0, irq_out}, 16'h0001);
    wr(3'd0, 16'h0020);
    idle(1);
    check("t4_out_none", {15'b0, irq_out}, 16'h0000);
    check("t4_idx_none", {12'b0, irq_idx}, 16'h0000);

    // 5: masking a pending line
    pulse(8'h02);
    idle(SD + 1);
    check("t5_out_pre", {15'b0, irq_out}, 16'h0001);
    wr(3'd1, 16'h0000);
    idle(1);
    check("t5_out_masked", {15'b0, irq_out}, 16'h0000);
    rd(3'd3, 16'h0000, "t5_active_masked");
    rd(3'd0, 16'h0002, "t5_pending_kept");
    wr(3'd1, 16'h0002);
    idle(1);
    check("t5_out_unmask", {15'b0, irq_out}, 16'h0001);
    check("t5_idx_unmask", {12'b0, irq_idx}, 16'h0001);
    rd(3'd3, 16'h8001, "t5_active");

    // 6: unmapped addresses and upper bits
    rd(3'd5, 16'h0000, "t6_addr5");
    rd(3'd6, 16'h0000, "t6_addr6");
    rd(3'd7, 16'h0000, "t6_addr7");
    wr(3'd5, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
    wr(3'd7, 16'hFFFF);
    rd(3'd1, 16'h0002, "t6_mask_kept");
    rd(3'd2, 16'h00FF, "t6_edge_kept");
    rd(3'd0, 16'h0002, "t6_pending_kept");
    wr(3'd1, 16'hFF06);
    rd(3'd1, 16'h0006, "t6_mask_upper");
    irq_in = 8'hA5;
    idle(SD + 1);
    rd(3'd4, 16'h00A5, "t6_raw");
    irq_in = 8'h00;
    idle(SD + 2);

    // reset mid-operation clears captured state
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rst_out", {15'b0, irq_out}, 16'h0000);
    rd(3'd0, 16'h0000, "rst_pending");
    rd(3'd1, 16'h0000, "rst_mask");

    // edge-to-irq_out latency
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    idle(SD + 1);
    irq_in = 8'h01;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      irq_in = 8'h00;
      if (irq_out) begin k = c; break; end
    end
    check("latency", 16'(k), 16'(LAT));

    idle(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
